// File: rtl/spc7110_pkg.sv
// Shared definitions for the SPC7110 ROM port arbiter.
//   arb_state_t   : arbiter states (IDLE, SNES, TURN, CORD)
//   req_id_t      : coprocessor requester IDs (REQ_DCU = 0, REQ_DDP = 1)
//   RD_CYCLES_DEF : default number of cycles MEM_OE is held per coprocessor read
package spc7110_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // port free
    SNES = 2'd1,  // SNES bus owns the port
    TURN = 2'd2,  // dead cycle after an SNES access
    CORD = 2'd3   // coprocessor read in flight
  } arb_state_t;

  typedef enum logic {
    REQ_DCU = 1'b0,
    REQ_DDP = 1'b1
  } req_id_t;

  localparam int RD_CYCLES_DEF = 5;

endpackage

// File: rtl/spc7110_rr_pick.sv
// Two-way requester selector for the SPC7110 ROM arbiter.
// Build option: SPC7110_ARB_RR_EN
//   defined   : round-robin; when both request, the one not granted last wins.
//   undefined : fixed priority DCU > DDP; last_grant is ignored.
// Ports:
//   reqs       in  [1:0] request levels, indexed by req_id_t
//   last_grant in        requester granted by the last completed read
//   grant      out       selected requester (meaningful when valid)
//   valid      out       at least one request is pending
module spc7110_rr_pick
  import spc7110_pkg::*;
(
  input  logic [1:0] reqs,
  input  req_id_t    last_grant,
  output req_id_t    grant,
  output logic       valid
);

`ifndef SPC7110_ARB_RR_EN
  // The priority mux has no rotation state to look at.
  logic unused_last_grant;
  assign unused_last_grant = (last_grant == REQ_DDP);
`endif

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    grant = REQ_DCU;
    valid = reqs[0] | reqs[1];
`ifdef SPC7110_ARB_RR_EN
    if (reqs[0] && reqs[1]) begin
      grant = (last_grant == REQ_DCU) ? REQ_DDP : REQ_DCU;
    end else if (reqs[1]) begin
      grant = REQ_DDP;
    end
`else
    if (!reqs[0] && reqs[1]) begin
      grant = REQ_DDP;
    end
`endif
  end

endmodule

// File: rtl/spc7110_rom_arbiter.sv
// Shares the cartridge ROM/SRAM port between the SNES bus and the two SPC7110
// fetch engines (DCU and DDP). SNES cycles cannot be stalled, so they always
// preempt a coprocessor read; a preempted read is dropped without ack and
// re-arbitrates once the port is free again.
// Build option: SPC7110_ARB_RR_EN selects round-robin DCU/DDP arbitration;
// without it the DCU has fixed priority over the DDP.
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   snes_req/we/addr      SNES access request (level), write flag, address
//   dcu_req/addr          DCU read request (level, held until ack), address
//   dcu_ack/data          one-cycle ack pulse with the read byte
//   ddp_req/addr/ack/data same set for the DDP
//   MEM_ADDR/OE/WE, MEM_DI  memory pins
//   busy                  high exactly while a coprocessor read is in flight
module spc7110_rom_arbiter
  import spc7110_pkg::*;
#(
  parameter int ADDR_W    = 24,
  parameter int RD_CYCLES = RD_CYCLES_DEF  // 2..15
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              snes_req,
  input  logic              snes_we,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic              dcu_req,
  input  logic [ADDR_W-1:0] dcu_addr,
  output logic              dcu_ack,
  output logic [7:0]        dcu_data,
  input  logic              ddp_req,
  input  logic [ADDR_W-1:0] ddp_addr,
  output logic              ddp_ack,
  output logic [7:0]        ddp_data,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_OE,
  output logic              MEM_WE,
  input  logic [7:0]        MEM_DI,
  output logic              busy
);

  localparam logic [3:0] CNT_LAST = 4'(RD_CYCLES - 1);

  arb_state_t state;
  logic [3:0] cnt;
  req_id_t    grant_id;    // owner of the read in flight
  req_id_t    pick_grant;
  logic       pick_valid;

`ifdef SPC7110_ARB_RR_EN
  req_id_t    last_grant;  // moves only on a completed (acked) read
`endif

  spc7110_rr_pick u_pick (
    .reqs       ({ddp_req, dcu_req}),
`ifdef SPC7110_ARB_RR_EN
    .last_grant (last_grant),
`else
    .last_grant (REQ_DDP),
`endif
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // All outputs are registered; MEM_OE and MEM_WE are always written together
  // from one decision, so they can never both be high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state    <= IDLE;
      cnt      <= '0;
      grant_id <= REQ_DCU;
      MEM_ADDR <= '0;
      MEM_OE   <= 1'b0;
      MEM_WE   <= 1'b0;
      dcu_ack  <= 1'b0;
      ddp_ack  <= 1'b0;
      // NOTE: the read-data registers are plain flops, not a memory array, so
      // they are reset to a known value like everything else.
      dcu_data <= '0;
      ddp_data <= '0;
      busy     <= 1'b0;
`ifdef SPC7110_ARB_RR_EN
      last_grant <= REQ_DDP;  // DCU wins the first contested grant
`endif
    end else begin
      dcu_ack <= 1'b0;
      ddp_ack <= 1'b0;

      unique case (state)
        IDLE: begin
          if (snes_req) begin
            state    <= SNES;
            MEM_ADDR <= snes_addr;
            MEM_OE   <= !snes_we;
            MEM_WE   <= snes_we;
          end else if (pick_valid) begin
            state    <= CORD;
            grant_id <= pick_grant;
            MEM_ADDR <= (pick_grant == REQ_DDP) ? ddp_addr : dcu_addr;
            MEM_OE   <= 1'b1;
            MEM_WE   <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b1;
          end
        end

        SNES: begin
          if (snes_req) begin
            MEM_ADDR <= snes_addr;
            MEM_OE   <= !snes_we;
            MEM_WE   <= snes_we;
          end else begin
            state  <= TURN;
            MEM_OE <= 1'b0;
            MEM_WE <= 1'b0;
          end
        end

        TURN: begin
          state <= IDLE;
        end

        CORD: begin
          if (snes_req) begin
            // Preemption wins even on the final count: the read is dropped
            // with no ack and the still-pending request re-arbitrates later.
            state    <= SNES;
            MEM_ADDR <= snes_addr;
            MEM_OE   <= !snes_we;
            MEM_WE   <= snes_we;
            cnt      <= '0;
            busy     <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state  <= IDLE;
            MEM_OE <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            if (grant_id == REQ_DDP) begin
              ddp_data <= MEM_DI;
              ddp_ack  <= 1'b1;
            end else begin
              dcu_data <= MEM_DI;
              dcu_ack  <= 1'b1;
            end
`ifdef SPC7110_ARB_RR_EN
            last_grant <= grant_id;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
